// File: rtl/npu_mem_arbiter.sv
// rtl/npu_mem_arbiter.sv - 2:1 round-robin arbiter for the native memory bus with a BUSY watchdog
module npu_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    s0_mem_valid,
    output logic                    s0_mem_ready,
    input  logic [ADDR_WIDTH-1:0]   s0_mem_addr,
    input  logic [DATA_WIDTH-1:0]   s0_mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_mem_wstrb,
    output logic [DATA_WIDTH-1:0]   s0_mem_rdata,

    input  logic                    s1_mem_valid,
    output logic                    s1_mem_ready,
    input  logic [ADDR_WIDTH-1:0]   s1_mem_addr,
    input  logic [DATA_WIDTH-1:0]   s1_mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_mem_wstrb,
    output logic [DATA_WIDTH-1:0]   s1_mem_rdata,

    output logic                    m_mem_valid,
    input  logic                    m_mem_ready,
    output logic [ADDR_WIDTH-1:0]   m_mem_addr,
    output logic [DATA_WIDTH-1:0]   m_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] m_mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   m_mem_rdata,

    output logic                    grant_id,
    output logic                    timeout_pulse,
    output logic [7:0]              timeout_count
);
    localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                  state;
    logic                    last_winner;
    logic [31:0]             wdog;
    logic                    pick1;
    logic                    expire;
    logic [DATA_WIDTH-1:0]   done_data;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        pick1     = s1_mem_valid && (!s0_mem_valid || !last_winner);
        expire    = WD_EN && (wdog == WD_LAST);
        done_data = m_mem_ready ? m_mem_rdata : ERR_RDATA;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_winner   <= 1'b1;
            wdog          <= '0;
            grant_id      <= 1'b0;
            m_mem_valid   <= 1'b0;
            m_mem_addr    <= '0;
            m_mem_wdata   <= '0;
            m_mem_wstrb   <= '0;
            s0_mem_ready  <= 1'b0;
            s1_mem_ready  <= 1'b0;
            s0_mem_rdata  <= '0;
            s1_mem_rdata  <= '0;
            timeout_pulse <= 1'b0;
            timeout_count <= '0;
        end else begin
            s0_mem_ready  <= 1'b0;
            s1_mem_ready  <= 1'b0;
            s0_mem_rdata  <= '0;
            s1_mem_rdata  <= '0;
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (s0_mem_valid || s1_mem_valid) begin
                        m_mem_valid <= 1'b1;
                        m_mem_addr  <= pick1 ? s1_mem_addr  : s0_mem_addr;
                        m_mem_wdata <= pick1 ? s1_mem_wdata : s0_mem_wdata;
                        m_mem_wstrb <= pick1 ? s1_mem_wstrb : s0_mem_wstrb;
                        grant_id    <= pick1;
                        last_winner <= pick1;
                        wdog        <= '0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    // A ready arriving in the expiry cycle takes precedence over the watchdog.
                    if (m_mem_ready || expire) begin
                        m_mem_valid <= 1'b0;
                        state       <= RESP;
                        if (grant_id) begin
                            s1_mem_ready <= 1'b1;
                            s1_mem_rdata <= done_data;
                        end else begin
                            s0_mem_ready <= 1'b1;
                            s0_mem_rdata <= done_data;
                        end
                        if (!m_mem_ready) begin
                            timeout_pulse <= 1'b1;
                            if (timeout_count != 8'hFF)
                                timeout_count <= timeout_count + 8'd1;
                        end
                    end else begin
                        wdog <= wdog + 32'd1;
                    end
                end
                RESP: begin
                    wdog  <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
